// File: rtl/cache_pkg.sv
// Shared cache-line geometry, Block_Offset type and line-assembler state encoding.
package cache_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = 256;
    localparam int unsigned OFF_W     = 8;
    localparam int unsigned LINE_W    = BYTE_W * NUM_BYTES;

    // Byte index within a cache line; also used by the read-side byte extractor.
    typedef logic [OFF_W-1:0] block_offset_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } asm_state_e;

    // Fill counter value of the final (256th) byte of a line.
    localparam block_offset_t LAST_CNT = block_offset_t'(NUM_BYTES - 1);

endpackage

// File: rtl/line_byte_writer.sv
// Combinational byte-lane decoder: replaces one byte of a cache line when enabled.
module line_byte_writer
    import cache_pkg::*;
(
    input  logic [LINE_W-1:0] i_line,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_enable,
    output logic [LINE_W-1:0] o_line
);

    // Each lane either passes through or takes the new byte when it is the addressed lane.
    always_comb begin
        o_line = i_line;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (i_enable && (i_offset == block_offset_t'(k))) begin
                o_line[k*BYTE_W +: BYTE_W] = i_byte;
            end
        end
    end

endmodule

// File: rtl/byte_2_line_assembler.sv
// Assembles a cache line from a byte stream starting at a critical-byte offset, merges
// CPU byte writes while the line is held, and hands it to the data array via valid/ready.
module byte_2_line_assembler
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_fill_start,
    input  logic [OFF_W-1:0]     i_fill_offset,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [BYTE_W-1:0]    i_in_byte,
    input  logic                 i_wr_en,
    input  logic [OFF_W-1:0]     i_wr_offset,
    input  logic [BYTE_W-1:0]    i_wr_byte,
    output logic                 o_wr_drop,
    output logic [LINE_W-1:0]    o_line_out,
    output logic [NUM_BYTES-1:0] o_dirty_mask,
    output logic                 o_line_valid,
    input  logic                 i_line_ready,
    output logic                 o_busy
);

    asm_state_e           r_state;
    block_offset_t        r_ptr;
    block_offset_t        r_cnt;
    logic [LINE_W-1:0]    r_line;
    logic [NUM_BYTES-1:0] r_dirty;
    logic                 r_in_ready;
    logic                 r_line_valid;
    logic                 r_wr_drop;
    logic                 r_busy;

    logic                 w_fill_hs;
    logic                 w_line_hs;
    logic                 w_cpu_wr;
    logic                 w_lane_en;
    block_offset_t        w_lane_off;
    logic [BYTE_W-1:0]    w_lane_byte;
    logic [LINE_W-1:0]    w_line_next;

    // Handshakes and write qualification; a CPU write loses to the outgoing line handshake.
    always_comb begin
        w_fill_hs   = (r_state == FILL) && i_in_valid;
        w_line_hs   = (r_state == HOLD) && i_line_ready;
        w_cpu_wr    = (r_state == HOLD) && i_wr_en && !i_line_ready;
        w_lane_en   = w_fill_hs || w_cpu_wr;
        w_lane_off  = (r_state == FILL) ? r_ptr : i_wr_offset;
        w_lane_byte = (r_state == FILL) ? i_in_byte : i_wr_byte;
    end

    line_byte_writer u_line_byte_writer (
        .i_line   (r_line),
        .i_offset (w_lane_off),
        .i_byte   (w_lane_byte),
        .i_enable (w_lane_en),
        .o_line   (w_line_next)
    );

    // Control FSM with registered handshake/status outputs, line storage and dirty mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_line       <= '0;
            r_dirty      <= '0;
            r_in_ready   <= 1'b0;
            r_line_valid <= 1'b0;
            r_wr_drop    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Any CPU write not merged into the held line is reported one cycle later.
            r_wr_drop <= i_wr_en && !w_cpu_wr;
            if (w_lane_en) begin
                r_line <= w_line_next;
            end
            unique case (r_state)
                IDLE: begin
                    if (i_fill_start) begin
                        r_state    <= FILL;
                        r_ptr      <= i_fill_offset;
                        r_cnt      <= '0;
                        r_dirty    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (w_fill_hs) begin
                        r_ptr <= r_ptr + block_offset_t'(1);
                        r_cnt <= r_cnt + block_offset_t'(1);
                        if (r_cnt == LAST_CNT) begin
                            r_state      <= HOLD;
                            r_in_ready   <= 1'b0;
                            r_line_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_line_hs) begin
                        r_state      <= IDLE;
                        r_line_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_cnt        <= '0;
                    end else if (w_cpu_wr) begin
                        r_dirty[i_wr_offset] <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_in_ready   <= 1'b0;
                    r_line_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_line_valid = r_line_valid;
    assign o_wr_drop    = r_wr_drop;
    assign o_busy       = r_busy;
    assign o_line_out   = r_line;
    assign o_dirty_mask = r_dirty;

endmodule

// File: tb/tb_byte_2_line_assembler.sv
// Scoreboard bench: stimulus pushes expected lines, a monitor checks each line handoff.
module tb_byte_2_line_assembler;
    import cache_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 fill_start = 1'b0;
    logic [OFF_W-1:0]     fill_offset = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [BYTE_W-1:0]    in_byte = '0;
    logic                 wr_en = 1'b0;
    logic [OFF_W-1:0]     wr_offset = '0;
    logic [BYTE_W-1:0]    wr_byte = '0;
    logic                 wr_drop;
    logic [LINE_W-1:0]    line_out;
    logic [NUM_BYTES-1:0] dirty_mask;
    logic                 line_valid;
    logic                 line_ready = 1'b0;
    logic                 busy;

    byte_2_line_assembler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fill_start (fill_start),
        .i_fill_offset(fill_offset),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_byte    (in_byte),
        .i_wr_en      (wr_en),
        .i_wr_offset  (wr_offset),
        .i_wr_byte    (wr_byte),
        .o_wr_drop    (wr_drop),
        .o_line_out   (line_out),
        .o_dirty_mask (dirty_mask),
        .o_line_valid (line_valid),
        .i_line_ready (line_ready),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LINE_W-1:0]    line;
        logic [NUM_BYTES-1:0] dirty;
    } exp_t;

    exp_t                 q[$];
    exp_t                 mon_e;
    logic [BYTE_W-1:0]    exp_line[NUM_BYTES];
    logic [NUM_BYTES-1:0] exp_dirty;
    int                   checks = 0;
    int                   failures = 0;
    int                   exp_drops = 0;
    int                   seen_drops = 0;
    int unsigned          cyc = 0;
    int unsigned          start_cyc = 0;
    int unsigned          vcyc;
    logic [NUM_BYTES-1:0] bit16;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] req, input logic [NUM_BYTES-1:0] ad,
                            input logic [NUM_BYTES-1:0] rd);
        int bad_b = -1;
        int bad_d = -1;
        checks++;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (bad_b < 0 && act[k*BYTE_W +: BYTE_W] !== req[k*BYTE_W +: BYTE_W]) bad_b = k;
            if (bad_d < 0 && ad[k] !== rd[k]) bad_d = k;
        end
        if (bad_b >= 0 || bad_d >= 0) begin
            failures++;
            if (bad_b >= 0)
                $display("FAIL %s: byte[%0d] got 0x%02h expected 0x%02h", name, bad_b,
                         act[bad_b*BYTE_W +: BYTE_W], req[bad_b*BYTE_W +: BYTE_W]);
            else
                $display("FAIL %s: dirty[%0d] got %b expected %b", name, bad_d,
                         ad[bad_d], rd[bad_d]);
        end
    endtask

    function automatic logic [LINE_W-1:0] pack_exp();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < NUM_BYTES; k++) l[k*BYTE_W +: BYTE_W] = exp_line[k];
        return l;
    endfunction

    // Monitor: compare every line handoff against the oldest expectation; count wr_drop pulses.
    always @(negedge clk) begin
        if (rst_n && line_valid && line_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_handoff: got a line expected none");
            end else begin
                mon_e = q.pop_front();
                chk_line("line_handoff", line_out, mon_e.line, dirty_mask, mon_e.dirty);
            end
        end
        if (rst_n && wr_drop) seen_drops++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a fill and stream up to 'limit' bytes base, base+1, ... starting at 'off'.
    task automatic run_fill(input logic [7:0] off, input logic [7:0] base, input bit gaps,
                            input bit strays, input int limit);
        int  n = 0;
        bit  early = 0;
        fill_start  = 1'b1;
        fill_offset = off;
        start_cyc   = cyc;
        step();
        fill_start  = 1'b0;
        fill_offset = 8'hC3;
        for (int t = 0; t < 3000 && n < limit; t++) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_byte  = base + 8'(n);
            if (strays && (t % 37) == 5) begin
                fill_start  = 1'b1;
                fill_offset = 8'h33;
            end
            if (strays && (t % 53) == 7) begin
                wr_en     = 1'b1;
                wr_offset = 8'(t);
                wr_byte   = 8'hEE;
                exp_drops++;
            end
            @(negedge clk);
            if (t == 0) chk("in_ready_latency", in_ready, 1);
            if (line_valid) early = 1;
            if (in_ready && in_valid) begin
                exp_line[8'(off + 8'(n))] = base + 8'(n);
                n++;
            end
            step();
            fill_start = 1'b0;
            wr_en      = 1'b0;
            in_valid   = 1'b0;
        end
        exp_dirty = '0;
        chk("fill_handshakes", n, limit);
        chk("early_line_valid", early, 0);
    endtask

    task automatic wait_valid(output int unsigned vc);
        bit seen = 0;
        vc = 0;
        for (int t = 0; t < 16 && !seen; t++) begin
            @(negedge clk);
            if (line_valid) begin
                seen = 1;
                vc   = cyc;
            end
        end
        chk("line_valid_timeout", seen, 1);
        step();
    endtask

    task automatic cpu_write(input logic [7:0] off, input logic [7:0] b);
        wr_en     = 1'b1;
        wr_offset = off;
        wr_byte   = b;
        exp_line[off] = b;
        exp_dirty[off] = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic consume(input bit with_wr, input logic [7:0] woff, input logic [7:0] wb);
        exp_t e;
        e.line  = pack_exp();
        e.dirty = exp_dirty;
        q.push_back(e);
        line_ready = 1'b1;
        if (with_wr) begin
            wr_en     = 1'b1;
            wr_offset = woff;
            wr_byte   = wb;
            exp_drops++;
        end
        step();
        line_ready = 1'b0;
        wr_en      = 1'b0;
        @(negedge clk);
        chk("idle_after_handoff_busy", busy, 0);
        chk("idle_after_handoff_valid", line_valid, 0);
        if (with_wr) chk("wr_drop_on_handoff", wr_drop, 1);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NUM_BYTES; k++) exp_line[k] = '0;
        exp_dirty = '0;
        bit16     = '0;
        bit16[16] = 1'b1;

        // Reset values.
        step();
        step();
        @(negedge clk);
        chk("rst_line", |line_out, 0);
        chk("rst_dirty", |dirty_mask, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_wr_drop", wr_drop, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Straight fill 0x00..0xFF from offset 0.
        run_fill(8'h00, 8'h00, 1'b0, 1'b0, 256);
        wait_valid(vcyc);
        chk("s1_valid_latency", vcyc - start_cyc, 257);
        chk("s1_byte7b", line_out[8'h7B*8 +: 8], 8'h7B);
        chk("s1_in_ready_hold", in_ready, 0);
        consume(1'b0, 8'h00, 8'h00);

        // Critical-byte fill from 0xFE with wrap, then CPU writes in HOLD.
        run_fill(8'hFE, 8'hA0, 1'b0, 1'b0, 256);
        wait_valid(vcyc);
        chk("s2_byteFE", line_out[8'hFE*8 +: 8], 8'hA0);
        chk("s2_byteFF", line_out[8'hFF*8 +: 8], 8'hA1);
        chk("s2_byte00", line_out[7:0], 8'hA2);
        cpu_write(8'h10, 8'h5A);
        cpu_write(8'h10, 8'h77);
        @(negedge clk);
        chk("s3_byte10", line_out[8'h10*8 +: 8], 8'h77);
        chk("s3_dirty_low", dirty_mask[63:0], bit16[63:0]);
        chk("s3_dirty_rest", |dirty_mask[NUM_BYTES-1:64], 0);
        step();
        consume(1'b0, 8'h00, 8'h00);
        chk("s3_no_drops", seen_drops, 0);

        // CPU write colliding with the outgoing handshake is dropped.
        run_fill(8'h80, 8'h00, 1'b0, 1'b0, 256);
        wait_valid(vcyc);
        consume(1'b1, 8'h20, 8'h33);
        chk("s4_byte20_kept", line_out[8'h20*8 +: 8], 8'hA0);
        chk("s4_dirty32", dirty_mask[32], 0);
        chk("s4_drop_count", seen_drops, exp_drops);

        // Fill with random gaps plus stray fill_start and wr_en pulses.
        run_fill(8'h5C, 8'h31, 1'b1, 1'b1, 256);
        wait_valid(vcyc);
        consume(1'b0, 8'h00, 8'h00);
        chk("s5_drop_count", seen_drops, exp_drops);

        // Asynchronous reset after 100 bytes aborts the fill.
        run_fill(8'h00, 8'h55, 1'b0, 1'b0, 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_line", |line_out, 0);
        chk("arst_dirty", |dirty_mask, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_line_valid", line_valid, 0);
        for (int k = 0; k < NUM_BYTES; k++) exp_line[k] = '0;
        exp_dirty = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        run_fill(8'h00, 8'h00, 1'b0, 1'b0, 256);
        wait_valid(vcyc);
        chk("s6_valid_latency", vcyc - start_cyc, 257);
        consume(1'b0, 8'h00, 8'h00);

        chk("queue_drained", q.size(), 0);
        chk("final_drop_count", seen_drops, exp_drops);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_2_line_assembler.md
Name: byte_2_line_assembler

Overview:
- Write-direction counterpart of the cache's offset-to-byte read path.
- Builds a 2048-bit cache line from a byte-wide memory stream, starting at a critical-byte offset and wrapping.
- While holding the line, merges single-byte CPU writes at an 8-bit Block_Offset and tracks a per-byte dirty mask.
- Presents the finished line to the cache data array over a valid/ready handshake.

Parameters:
- BYTE_W, 8, bits per byte lane.
- NUM_BYTES, 256, bytes per cache line (line width = BYTE_W*NUM_BYTES = 2048).
- OFF_W, 8, Block_Offset width; log2(NUM_BYTES).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fill_start  input  1  one-cycle request to begin a line fill; honoured only in IDLE.
- fill_offset  input  OFF_W  first Block_Offset of the fill stream (critical byte).
- in_valid  input  1  memory byte valid.
- in_ready  output  1  assembler accepts a memory byte.
- in_byte  input  BYTE_W  memory data byte.
- wr_en  input  1  CPU byte-write strobe.
- wr_offset  input  OFF_W  CPU write Block_Offset.
- wr_byte  input  BYTE_W  CPU write data.
- wr_drop  output  1  one-cycle pulse: wr_en was not applied.
- line_out  output  BYTE_W*NUM_BYTES  assembled line; byte k at bits [8k+7:8k].
- dirty_mask  output  NUM_BYTES  bit k set when byte k was CPU-written since fill_start.
- line_valid  output  1  line_out complete and stable.
- line_ready  input  1  consumer takes the line.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - line_out = 0, dirty_mask = 0, in_ready = 0, line_valid = 0, wr_drop = 0, busy = 0.
  - Internal pointer and counter = 0.
  - Reset asserted mid-fill or mid-hold aborts immediately; no partial line is presented.
- States: IDLE, FILL, HOLD. All outputs are registered or decoded from state; no input-to-output combinational path.
- IDLE:
  - fill_start=1 -> FILL next cycle.
  - ptr <= fill_offset, cnt <= 0, dirty_mask <= 0.
  - line_out keeps its old contents until bytes overwrite them.
- FILL:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready: write in_byte to line_out byte[ptr], then ptr <= ptr+1 mod 256 (wraps 255 -> 0) and cnt <= cnt+1.
  - The handshake with cnt==255 (256th byte) -> HOLD next cycle.
  - Minimum fill is 256 cycles; in_valid gaps stall with no side effects.
- HOLD:
  - line_valid = 1, in_ready = 0.
  - wr_en=1 (no handshake this cycle): line_out byte[wr_offset] <= wr_byte and dirty_mask[wr_offset] <= 1; visible on the next cycle.
  - line_valid & line_ready -> IDLE next cycle; line_valid drops that next cycle.
  - line_out and dirty_mask hold their values in IDLE until the next fill_start.
- Simultaneous events:
  - wr_en with the HOLD handshake in the same cycle: the write is not applied and wr_drop pulses next cycle. The consumer receives the pre-write line.
  - wr_en in IDLE or FILL: ignored, wr_drop pulses.
  - fill_start outside IDLE: ignored, no effect.
  - fill_start and the HOLD handshake in the same cycle: fill_start ignored; it must be reissued in IDLE.
  - Back-to-back CPU writes to the same offset: last write wins; the dirty bit stays 1.
- Width rules:
  - ptr is OFF_W bits with natural wrap.
  - cnt is OFF_W bits; completion is detected at cnt==NUM_BYTES-1 with a handshake, never by overflow.
- Latency:
  - fill_start to first in_ready: 1 cycle.
  - Last byte handshake to line_valid: 1 cycle.

Decomposition:
- Shared package cache_pkg holds:
  - BYTE_W, NUM_BYTES, OFF_W, LINE_W.
  - The state enum {IDLE, FILL, HOLD}.
  - The Block_Offset typedef, also used by the read-side byte extractor.
- One natural sub-module, line_byte_writer: combinational byte-lane decoder.
  - Inputs: line, offset, byte, enable.
  - Output: the updated line, with byte[offset] replaced when enable=1.
  - Instantiated once; the FILL path drives it from ptr/in_byte and the HOLD path from wr_offset/wr_byte.
- The FSM, counter, dirty mask and handshake stay in byte_2_line_assembler.

Test Plan:
- Reset, then fill_offset=0x00 and stream bytes 0x00..0xFF with in_valid held high.
  - line_valid rises exactly 257 cycles after fill_start.
  - byte[k]=k for all k; dirty_mask=0.
- Critical-byte fill with fill_offset=0xFE, stream values 0xA0,0xA1,0xA2,...
  - byte[0xFE]=0xA0, byte[0xFF]=0xA1, byte[0x00]=0xA2 (wrap).
  - line_valid only after 256 handshakes.
- HOLD, wr_en at offset 0x10 with 0x5A, then offset 0x10 with 0x77, then line_ready.
  - Consumer sees byte[0x10]=0x77.
  - dirty_mask has only bit 16 set; wr_drop never pulses.
- wr_en at offset 0x20 with 0x33 in the same cycle as the line_valid & line_ready handshake.
  - Byte[0x20] is unchanged and dirty bit 32 stays 0.
  - wr_drop pulses one cycle; state is IDLE next cycle.
- Random in_valid gaps during a fill, plus stray fill_start and wr_en pulses mid-fill.
  - The fill completes correctly; stray fill_start has no effect; each stray wr_en gives one wr_drop.
- rst_n asserted low asynchronously after 100 fill bytes, then released and a fresh fill issued.
  - All outputs return to reset values immediately.
  - The next fill behaves as in the first scenario.
